// File: rtl/hazard5_muldiv_seq_pkg.sv
// Shared definitions for the Hazard5 iterative multiply/divide unit:
// funct3 operation encodings, FSM state encodings and small op-decode helpers.
package hazard5_muldiv_seq_pkg;

  // RV32M funct3 encodings.
  typedef enum logic [2:0] {
    MOpMul    = 3'b000,
    MOpMulh   = 3'b001,
    MOpMulhsu = 3'b010,
    MOpMulhu  = 3'b011,
    MOpDiv    = 3'b100,
    MOpDivu   = 3'b101,
    MOpRem    = 3'b110,
    MOpRemu   = 3'b111
  } m_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  function automatic logic op_is_div(m_op_e op);
    return op[2];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(m_op_e op);
    return (op == MOpMulh) || (op == MOpMulhsu) || (op == MOpDiv) || (op == MOpRem);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic op_signed_b(m_op_e op);
    return (op == MOpMulh) || (op == MOpDiv) || (op == MOpRem);
  endfunction

endpackage

// File: rtl/hazard5_muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: add operand into the upper half when the multiplier LSB is set, then shift right.
// Divide: shift left, compare-subtract the divisor, shift the quotient bit in at the bottom.
module hazard5_muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic              is_div_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] part;
  logic [XLEN:0] diff;

  // Single shift-add or restoring shift-subtract step.
  always_comb begin
    add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    part    = acc_i[2*XLEN-1:XLEN-1];
    diff    = part - {1'b0, opnd_i};
    if (is_div_i) begin
      // Top bit of diff is the borrow: clear means partial remainder >= divisor.
      if (!diff[XLEN]) begin
        acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {part[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/hazard5_muldiv_seq.sv
// Hazard5 iterative RV32M multiply/divide unit.
// Operates on operand magnitudes, one (or two) bits per cycle, with sign correction applied
// while presenting the single-cycle result strobe.
// Build option: define HAZARD5_MULDIV_UNROLL2_EN to chain two step instances per cycle,
// halving the iteration count; results are identical in both builds.
module hazard5_muldiv_seq
  import hazard5_muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_vld,
  output logic            op_rdy,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            op_kill,
  output logic [XLEN-1:0] result,
  output logic            result_vld
);

  localparam int unsigned CtrW = $clog2(XLEN) + 1;
`ifdef HAZARD5_MULDIV_UNROLL2_EN
  localparam logic [CtrW-1:0] CtrInit = CtrW'(XLEN / 2);
`else
  localparam logic [CtrW-1:0] CtrInit = CtrW'(XLEN);
`endif

  state_e              state_q, state_d;
  logic [CtrW-1:0]     ctr_q, ctr_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  m_op_e               op_q, op_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;

  m_op_e               op_in;
  logic                in_sign_a, in_sign_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [2*XLEN-1:0]   step0_acc, step_acc;

  assign op_in     = m_op_e'(op);
  assign in_sign_a = op_signed_a(op_in) && op_a[XLEN-1];
  assign in_sign_b = op_signed_b(op_in) && op_b[XLEN-1];
  assign mag_a     = in_sign_a ? -op_a : op_a;
  assign mag_b     = in_sign_b ? -op_b : op_b;

  hazard5_muldiv_step #(
    .XLEN(XLEN)
  ) u_step0 (
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .is_div_i(op_is_div(op_q)),
    .acc_o   (step0_acc)
  );

`ifdef HAZARD5_MULDIV_UNROLL2_EN
  hazard5_muldiv_step #(
    .XLEN(XLEN)
  ) u_step1 (
    .acc_i   (step0_acc),
    .opnd_i  (opnd_q),
    .is_div_i(op_is_div(op_q)),
    .acc_o   (step_acc)
  );
`else
  assign step_acc = step0_acc;
`endif

  // Next-state logic: accept in IDLE, iterate in RUN, single DONE cycle, kill returns to IDLE.
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    unique case (state_q)
      StIdle: begin
        if (op_vld && !op_kill) begin
          op_d     = op_in;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          ctr_d    = CtrInit;
          state_d  = StRun;
          // Divide: dividend in the low half; multiply: multiplier in the low half.
          if (op_is_div(op_in)) begin
            acc_d  = {{XLEN{1'b0}}, mag_a};
            opnd_d = mag_b;
          end else begin
            acc_d  = {{XLEN{1'b0}}, mag_b};
            opnd_d = mag_a;
          end
        end
      end
      StRun: begin
        if (op_kill) begin
          state_d = StIdle;
        end else begin
          acc_d = step_acc;
          ctr_d = ctr_q - 1'b1;
          if (ctr_q == CtrW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ctr_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= MOpMul;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;
  logic              quot_neg;

  assign prod     = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quot_neg = (sign_a_q ^ sign_b_q) && (opnd_q != '0);
  assign quot     = quot_neg ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem      = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  // Outputs: ready only in IDLE; sign-corrected result strobed in DONE unless killed.
  always_comb begin
    op_rdy     = (state_q == StIdle);
    result     = '0;
    result_vld = 1'b0;
    if (state_q == StDone) begin
      result_vld = !op_kill;
      unique case (op_q)
        MOpMul:                      result = prod[XLEN-1:0];
        MOpMulh, MOpMulhsu, MOpMulhu: result = prod[2*XLEN-1:XLEN];
        MOpDiv, MOpDivu:             result = quot;
        MOpRem, MOpRemu:             result = rem;
        default:                     result = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard5_muldiv_seq.sv
// Self-checking bench for hazard5_muldiv_seq: vector table plus kill/reset sequences.
module tb_hazard5_muldiv_seq;

  localparam int unsigned XLEN = 32;
`ifdef HAZARD5_MULDIV_UNROLL2_EN
  localparam int ExpLat = 17;
`else
  localparam int ExpLat = 33;
`endif
  localparam int MaxWait = 80;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            op_vld = 1'b0;
  logic            op_rdy;
  logic [2:0]      op = 3'b000;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            op_kill = 1'b0;
  logic [XLEN-1:0] result;
  logic            result_vld;

  int checks = 0;
  int errors = 0;

  hazard5_muldiv_seq #(
    .XLEN(XLEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_vld    (op_vld),
    .op_rdy    (op_rdy),
    .op        (op),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_kill   (op_kill),
    .result    (result),
    .result_vld(result_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1. Issues one op, waits for result_vld (bounded).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit rdy_ok);
    bit found;
    op_vld = 1'b1;
    op     = o;
    op_a   = a;
    op_b   = b;
    rdy_ok = op_rdy;
    @(posedge clk);
    #1;
    // Later operand changes must have no effect.
    op_vld = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    lat    = 1;
    found  = 1'b0;
    res    = '0;
    while (!found && lat < MaxWait) begin
      if (op_rdy) rdy_ok = 1'b0;
      if (result_vld) begin
        found = 1'b1;
        res   = result;
      end else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    if (!found) lat = -1;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] res;
  int          lat;
  bit          rdy_ok;
  bit          seen_vld;

  initial begin
    vecs[0]  = '{"mul_7_m3",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{"mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{"mulhsu_ff",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3]  = '{"mulhu_ff",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[4]  = '{"div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    vecs[5]  = '{"rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[6]  = '{"divu_7_2",      3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC};
    vecs[7]  = '{"remu_7_2",      3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001};
    vecs[8]  = '{"div_5_0",       3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[9]  = '{"rem_5_0",       3'b110, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
    vecs[10] = '{"div_m5_0",      3'b100, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[11] = '{"rem_m5_0",      3'b110, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB};
    vecs[12] = '{"div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[13] = '{"rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[14] = '{"divu_5_0",      3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[15] = '{"mul_m6_m7",     3'b000, 32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'h0000_002A};

    // Reset state.
    #12;
    check("reset_rdy", {31'b0, op_rdy}, 32'h1);
    check("reset_vld", {31'b0, result_vld}, 32'h0);
    check("reset_result", result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Kill in IDLE blocks acceptance.
    op_vld  = 1'b1;
    op_kill = 1'b1;
    @(posedge clk);
    #1;
    op_vld  = 1'b0;
    op_kill = 1'b0;
    check("idle_kill_rdy", {31'b0, op_rdy}, 32'h1);

    // Table-driven vectors, issued back to back.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, rdy_ok);
      check({vecs[i].name, "_res"}, res, vecs[i].exp);
      check({vecs[i].name, "_lat"}, lat, ExpLat);
      check({vecs[i].name, "_rdy"}, {31'b0, rdy_ok}, 32'h1);
      check({vecs[i].name, "_rdy_after"}, {31'b0, op_rdy}, 32'h1);
    end

    // Kill mid-RUN: accept DIV, kill 10 cycles later.
    op_vld = 1'b1;
    op     = 3'b100;
    op_a   = 32'd100;
    op_b   = 32'd7;
    @(posedge clk);
    #1;
    op_vld = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    op_kill = 1'b1;
    @(posedge clk);
    #1;
    op_kill = 1'b0;
    check("kill_run_rdy", {31'b0, op_rdy}, 32'h1);
    seen_vld = 1'b0;
    repeat (40) begin
      if (result_vld) seen_vld = 1'b1;
      @(posedge clk);
      #1;
    end
    check("kill_run_no_vld", {31'b0, seen_vld}, 32'h0);
    run_op(3'b000, 32'd3, 32'd4, res, lat, rdy_ok);
    check("kill_then_mul", res, 32'd12);
    check("kill_then_mul_lat", lat, ExpLat);

    // Kill on the DONE cycle suppresses the strobe.
    op_vld = 1'b1;
    op     = 3'b000;
    op_a   = 32'd9;
    op_b   = 32'd9;
    @(posedge clk);
    #1;
    op_vld = 1'b0;
    lat = 1;
    while (!result_vld && lat < MaxWait) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_kill_reach", lat, ExpLat);
    op_kill = 1'b1;
    #1;
    check("done_kill_vld", {31'b0, result_vld}, 32'h0);
    @(posedge clk);
    #1;
    op_kill = 1'b0;
    check("done_kill_rdy", {31'b0, op_rdy}, 32'h1);
    check("done_kill_vld_after", {31'b0, result_vld}, 32'h0);

    // Asynchronous reset mid-RUN.
    op_vld = 1'b1;
    op     = 3'b101;
    op_a   = 32'd1000;
    op_b   = 32'd3;
    @(posedge clk);
    #1;
    op_vld = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_rdy", {31'b0, op_rdy}, 32'h1);
    check("arst_vld", {31'b0, result_vld}, 32'h0);
    check("arst_result", result, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(3'b101, 32'd1000, 32'd3, res, lat, rdy_ok);
    check("arst_then_divu", res, 32'd333);
    check("arst_then_divu_lat", lat, ExpLat);
    run_op(3'b111, 32'd1000, 32'd3, res, lat, rdy_ok);
    check("arst_then_remu", res, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
